sar_capture_ctrl: RTL and testbench

//  Host-side sequencer and result reader for the SAR4 ADC controller. Parks the SAR in reset, issues start,

---
 rtl/sar_capture_ctrl_pkg.sv | 18 +
 rtl/sar_capture_ctrl_result_fifo.sv | 46 ++++
 rtl/sar_capture_ctrl.sv | 137 +++++++++++++
 tb/tb_sar_capture_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_capture_ctrl_pkg.sv
// Shared constants and FSM encoding for the SAR4 capture sequencer.
package sar_capture_ctrl_pkg;

   localparam int unsigned SarCodeW     = 5;
   localparam int unsigned SarFifoDepth = 4;
   localparam int unsigned SarCntW      = 4;
   localparam int unsigned SarTimeout   = 16;
   // Cycles between successive eoc pulses of a free-running SAR4.
   localparam int unsigned SarPeriod    = 7;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StArm  = 2'd1,
      StWait = 2'd2,
      StErr  = 2'd3
   } state_e;

endpackage

// File: rtl/sar_capture_ctrl_result_fifo.sv
// Synchronous result FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module sar_capture_ctrl_result_fifo #(
   parameter int unsigned Width = 6,
   parameter int unsigned Depth = 4
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [Width-1:0] i_data,
   input  logic             i_pop,
   output logic [Width-1:0] o_data,
   output logic             o_valid,
   output logic             o_full
);

   localparam int unsigned PtrW = $clog2(Depth) + 1;

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra MSB on each pointer distinguishes full from empty.
   assign o_valid   = (r_wptr != r_rptr);
   assign o_full    = (r_wptr[PtrW-1] != r_rptr[PtrW-1]) &&
                      (r_wptr[PtrW-2:0] == r_rptr[PtrW-2:0]);
   assign w_do_pop  = i_pop && o_valid;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = r_mem[r_rptr[PtrW-2:0]];

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PtrW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PtrW'(1);
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_do_push) r_mem[r_wptr[PtrW-2:0]] <= i_data;
   end

endmodule

// File: rtl/sar_capture_ctrl.sv
// Host-side SAR4 sequencer: parks the SAR in reset, starts bursts, captures codes on eoc into a
// FIFO with per-entry last flags, and watches for conversions that never complete.
module sar_capture_ctrl
   import sar_capture_ctrl_pkg::*;
#(
   parameter int unsigned CodeW     = SarCodeW,
   parameter int unsigned FifoDepth = SarFifoDepth,
   parameter int unsigned CntW      = SarCntW,
   parameter int unsigned Timeout   = SarTimeout
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_req,
   input  logic [CntW-1:0]  i_req_len,
   output logic             o_req_ready,
   output logic             o_busy,
   output logic             o_adc_start,
   output logic             o_adc_reset,
   input  logic             i_adc_eoc,
   input  logic [CodeW-1:0] i_adc_code,
   output logic             o_dout_valid,
   input  logic             i_dout_ready,
   output logic [CodeW-1:0] o_dout_data,
   output logic             o_dout_last,
   output logic             o_overflow,
   output logic             o_timeout_err
);

   localparam int unsigned WdogW = $clog2(Timeout);

   state_e           r_state;
   state_e           w_state_next;
   logic [CntW-1:0]  r_remaining;
   logic [WdogW-1:0] r_wdog;
   logic             r_overflow;
   logic             r_timeout_err;
   logic             w_accept;
   logic             w_eoc;
   logic             w_last;
   logic             w_wdog_fire;
   logic             w_pop;
   logic             w_full;
   logic             w_valid;
   logic [CodeW:0]   w_fifo_data;

   assign w_accept    = (r_state == StIdle) && i_req;
   assign w_eoc       = (r_state == StWait) && i_adc_eoc;
   assign w_last      = (r_remaining == CntW'(1));
   assign w_wdog_fire = (r_state == StWait) && !i_adc_eoc && (r_wdog == WdogW'(Timeout - 1));
   assign w_pop       = w_valid && i_dout_ready;

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= StIdle;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: if (i_req) w_state_next = StArm;
         StArm:  w_state_next = StWait;
         StWait: begin
            if (i_adc_eoc) begin
               if (w_last) w_state_next = StIdle;
            end else if (w_wdog_fire) begin
               w_state_next = StErr;
            end
         end
         StErr:   w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_req_ready = 1'b0;
      o_busy      = 1'b0;
      o_adc_start = 1'b0;
      o_adc_reset = 1'b0;
      unique case (r_state)
         StIdle: begin
            o_req_ready = 1'b1;
            o_adc_reset = 1'b1;
         end
         StArm: begin
            o_busy      = 1'b1;
            o_adc_start = 1'b1;
         end
         StWait:  o_busy = 1'b1;
         StErr:   o_adc_reset = 1'b1;
         default: o_adc_reset = 1'b1;
      endcase
   end

   // A zero-length request runs a single conversion.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_remaining <= '0;
         r_wdog      <= '0;
      end else begin
         if (w_accept)   r_remaining <= (i_req_len == '0) ? CntW'(1) : i_req_len;
         else if (w_eoc) r_remaining <= r_remaining - CntW'(1);
         if ((r_state == StArm) || w_eoc) r_wdog <= '0;
         else if (r_state == StWait)      r_wdog <= r_wdog + WdogW'(1);
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset || w_accept) begin
         r_overflow    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_eoc && w_full && !w_pop) r_overflow <= 1'b1;
         if (w_wdog_fire)               r_timeout_err <= 1'b1;
      end
   end

   sar_capture_ctrl_result_fifo #(
      .Width (CodeW + 1),
      .Depth (FifoDepth)
   ) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (w_eoc),
      .i_data  ({i_adc_code, w_last}),
      .i_pop   (i_dout_ready),
      .o_data  (w_fifo_data),
      .o_valid (w_valid),
      .o_full  (w_full)
   );

   assign o_dout_valid  = w_valid;
   assign o_dout_data   = w_fifo_data[CodeW:1];
   assign o_dout_last   = w_fifo_data[0];
   assign o_overflow    = r_overflow;
   assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sar_capture_ctrl.sv
// Bench for sar_capture_ctrl: behavioural SAR4 environment plus a timeline-based reference model.
module tb_sar_capture_ctrl;
   import sar_capture_ctrl_pkg::*;

   localparam int unsigned CW    = SarCodeW;
   localparam int unsigned DEPTH = SarFifoDepth;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               req = 1'b0;
   logic [SarCntW-1:0] req_len = '0;
   logic               dout_ready = 1'b0;
   logic               adc_eoc = 1'b0;
   logic [CW-1:0]      adc_code = '0;
   logic               req_ready, busy, adc_start, adc_reset;
   logic               dout_valid, dout_last, overflow, timeout_err;
   logic [CW-1:0]      dout_data;

   always #5 clk = ~clk;

   sar_capture_ctrl u_dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_req         (req),
      .i_req_len     (req_len),
      .o_req_ready   (req_ready),
      .o_busy        (busy),
      .o_adc_start   (adc_start),
      .o_adc_reset   (adc_reset),
      .i_adc_eoc     (adc_eoc),
      .i_adc_code    (adc_code),
      .o_dout_valid  (dout_valid),
      .i_dout_ready  (dout_ready),
      .o_dout_data   (dout_data),
      .o_dout_last   (dout_last),
      .o_overflow    (overflow),
      .o_timeout_err (timeout_err)
   );

   // SAR4 model: acts on negedge, free-runs after start, one eoc pulse every SarPeriod cycles.
   logic [CW-1:0] sar_codes[$];
   bit            sar_mute = 1'b0;
   bit            sar_run = 1'b0;
   int            sar_cnt = 0;

   always @(negedge clk) begin
      if (adc_reset === 1'b1) begin
         sar_run <= 1'b0;
         sar_cnt <= 0;
         adc_eoc <= 1'b0;
      end else if (adc_start === 1'b1) begin
         sar_run <= 1'b1;
         sar_cnt <= 0;
         adc_eoc <= 1'b0;
      end else if (sar_run) begin
         if (sar_cnt == int'(SarPeriod) - 1) begin
            sar_cnt <= 0;
            adc_eoc <= !sar_mute;
            if (!sar_mute && sar_codes.size() > 0) begin
               adc_code <= sar_codes[0];
               sar_codes.delete(0);
            end
         end else begin
            sar_cnt <= sar_cnt + 1;
            adc_eoc <= 1'b0;
         end
      end else begin
         adc_eoc <= 1'b0;
      end
   end

   int            e = 0;
   int            checks = 0;
   int            errors = 0;
   bit            m_idle = 1'b1;
   bit            m_mute = 1'b0;
   bit            m_ovf = 1'b0;
   bit            m_tmo = 1'b0;
   int            m_acc = 0;
   int            m_n = 0;
   int            m_k = 0;
   logic [CW-1:0] m_codes[$];
   logic [CW:0]   m_q[$];
   logic [CW-1:0] dir_codes[$];
   bit            want_req = 1'b0;
   bit            want_rst = 1'b1;
   bit            noise = 1'b0;
   int            rdy_mode = 0;
   int            rdy_edge = -1;
   int            t = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, e);
      end
   endtask

   // Burst accepted at edge A yields eoc at A+1+P*(k+1); a mute burst errors at A+1+Timeout.
   task automatic model_edge();
      bit pop;
      pop = dout_ready && (m_q.size() > 0);
      if (rst) begin
         m_q.delete();
         m_idle = 1'b1;
         m_ovf  = 1'b0;
         m_tmo  = 1'b0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (m_idle) begin
            if (req) begin
               m_idle = 1'b0;
               m_acc  = e;
               m_n    = (req_len == '0) ? 1 : int'(req_len);
               m_k    = 0;
               m_ovf  = 1'b0;
               m_tmo  = 1'b0;
               m_mute = sar_mute;
            end
         end else if (!m_mute) begin
            if (e == m_acc + 1 + int'(SarPeriod) * (m_k + 1)) begin
               if (m_q.size() < DEPTH) m_q.push_back({m_codes[m_k], (m_k == m_n - 1)});
               else                    m_ovf = 1'b1;
               m_k++;
               if (m_k == m_n) m_idle = 1'b1;
            end
         end else begin
            if (e == m_acc + 1 + int'(SarTimeout)) m_tmo = 1'b1;
            if (e == m_acc + 2 + int'(SarTimeout)) m_idle = 1'b1;
         end
      end
   endtask

   task automatic compare();
      bit          in_err;
      logic [CW:0] head;
      in_err = !m_idle && m_mute && (e == m_acc + 1 + int'(SarTimeout));
      check("req_ready", {7'd0, req_ready}, {7'd0, m_idle});
      check("busy", {7'd0, busy}, {7'd0, !m_idle && !in_err});
      check("adc_start", {7'd0, adc_start}, {7'd0, !m_idle && (e == m_acc)});
      check("adc_reset", {7'd0, adc_reset}, {7'd0, m_idle || in_err});
      check("dout_valid", {7'd0, dout_valid}, {7'd0, m_q.size() > 0});
      if (m_q.size() > 0) begin
         head = m_q[0];
         check("dout_data", {3'd0, dout_data}, {3'd0, head[CW:1]});
         check("dout_last", {7'd0, dout_last}, {7'd0, head[0]});
      end
      check("overflow", {7'd0, overflow}, {7'd0, m_ovf});
      if (!in_err) check("timeout_err", {7'd0, timeout_err}, {7'd0, m_tmo});
   endtask

   task automatic tick();
      rst = want_rst;
      if (m_idle) req = want_req;
      else        req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      case (rdy_mode)
         0:       dout_ready = 1'b0;
         1:       dout_ready = 1'b1;
         default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      if (e + 1 == rdy_edge) dout_ready = 1'b1;
      @(posedge clk);
      e++;
      model_edge();
      #1;
      compare();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic go(input int len, input bit mute);
      int            n;
      logic [CW-1:0] c;
      n = (len == 0) ? 1 : len;
      sar_codes.delete();
      m_codes.delete();
      for (int i = 0; i < n; i++) begin
         if (i < int'(dir_codes.size())) c = dir_codes[i];
         else                            c = CW'($urandom);
         sar_codes.push_back(c);
         m_codes.push_back(c);
      end
      dir_codes.delete();
      sar_mute = mute;
      req_len  = SarCntW'(len);
      want_req = 1'b1;
      tick();
      want_req = 1'b0;
      t = e;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check("wait_idle", {7'd0, req_ready}, 8'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_time_limit edge=%0d", e);
      $fatal(1, "time limit");
   end

   initial begin
      want_rst = 1'b1;
      run(3);
      want_rst = 1'b0;
      run(2);
      check("rst_req_ready", {7'd0, req_ready}, 8'd1);
      check("rst_adc_reset", {7'd0, adc_reset}, 8'd1);
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_dout_valid", {7'd0, dout_valid}, 8'd0);

      // Single shot
      rdy_mode = 0;
      dir_codes.push_back(5'b10110);
      go(1, 1'b0);
      run(7);
      check("t1_valid_early", {7'd0, dout_valid}, 8'd0);
      run(1);
      check("t1_data", {3'd0, dout_data}, 8'd22);
      check("t1_last", {7'd0, dout_last}, 8'd1);
      check("t1_adc_reset", {7'd0, adc_reset}, 8'd1);
      rdy_mode = 1;
      run(3);

      // Burst of three with consumer ready
      dir_codes.push_back(5'd3);
      dir_codes.push_back(5'd17);
      dir_codes.push_back(5'd30);
      go(3, 1'b0);
      run(8);
      check("t2_data0", {3'd0, dout_data}, 8'd3);
      check("t2_last0", {7'd0, dout_last}, 8'd0);
      run(7);
      check("t2_data1", {3'd0, dout_data}, 8'd17);
      run(6);
      check("t2_busy_before", {7'd0, busy}, 8'd1);
      run(1);
      check("t2_data2", {3'd0, dout_data}, 8'd30);
      check("t2_last2", {7'd0, dout_last}, 8'd1);
      check("t2_busy_after", {7'd0, busy}, 8'd0);
      run(3);

      // Overflow with stalled consumer
      rdy_mode = 0;
      go(6, 1'b0);
      run(35);
      check("t3_ovf_before", {7'd0, overflow}, 8'd0);
      run(1);
      check("t3_ovf_after", {7'd0, overflow}, 8'd1);
      wait_idle();
      rdy_mode = 1;
      run(6);
      check("t3_ovf_sticky", {7'd0, overflow}, 8'd1);

      // Full FIFO with a pop on the fifth eoc edge
      rdy_mode = 0;
      go(5, 1'b0);
      check("t4_ovf_cleared", {7'd0, overflow}, 8'd0);
      rdy_edge = t + 1 + 5 * int'(SarPeriod);
      wait_idle();
      rdy_edge = -1;
      check("t4_no_ovf", {7'd0, overflow}, 8'd0);

      // Watchdog timeout
      go(2, 1'b1);
      run(16);
      check("t5_busy", {7'd0, busy}, 8'd1);
      run(1);
      check("t5_err_busy", {7'd0, busy}, 8'd0);
      check("t5_err_adc_reset", {7'd0, adc_reset}, 8'd1);
      run(1);
      check("t5_timeout_err", {7'd0, timeout_err}, 8'd1);
      check("t5_req_ready", {7'd0, req_ready}, 8'd1);

      // Reset in the third WAIT cycle
      go(4, 1'b0);
      run(3);
      check("t6_valid_held", {7'd0, dout_valid}, 8'd1);
      want_rst = 1'b1;
      tick();
      want_rst = 1'b0;
      check("t6_dout_valid", {7'd0, dout_valid}, 8'd0);
      check("t6_adc_reset", {7'd0, adc_reset}, 8'd1);
      check("t6_req_ready", {7'd0, req_ready}, 8'd1);
      check("t6_overflow", {7'd0, overflow}, 8'd0);
      check("t6_timeout_err", {7'd0, timeout_err}, 8'd0);
      run(2);

      // Randomized bursts with ignored requests while busy
      for (int b = 0; b < 16; b++) begin
         rdy_mode = int'($urandom_range(0, 2));
         noise    = 1'($urandom_range(0, 1));
         go(int'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
         wait_idle();
         run(int'($urandom_range(0, 3)));
      end
      noise = 1'b0;
      rdy_mode = 1;
      run(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
